// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
// Optional build macro PS2_GLITCH_FILTER_EN is consumed by ps2_sync_edge.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } ps2_key_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 lines and produces a falling-edge strobe on ps2_clk.
// Define PS2_GLITCH_FILTER_EN to insert a 4-sample stability filter on the clock line.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic fe,
  output logic data_sync
);

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_level;
  logic                   clk_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data_in};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  logic       clk_filt_reg;
  logic [1:0] filt_cnt_reg;

  // Level follows the synced line only after 4 consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_reg <= 1'b1;
      filt_cnt_reg <= 2'd0;
    end else if (clk_sync_reg[SYNC_STAGES-1] != clk_filt_reg) begin
      if (filt_cnt_reg == 2'd3) begin
        clk_filt_reg <= clk_sync_reg[SYNC_STAGES-1];
        filt_cnt_reg <= 2'd0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 2'd1;
      end
    end else begin
      filt_cnt_reg <= 2'd0;
    end
  end

  assign clk_level = clk_filt_reg;
`else
  assign clk_level = clk_sync_reg[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_prev_reg <= 1'b1;
    else          clk_prev_reg <= clk_level;
  end

  assign fe        = clk_prev_reg & ~clk_level;
  assign data_sync = data_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into flags and
// emits the {toggle, pressed, extended, code} event word.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_rx_state_t   state_reg, state_next;
  logic            fe, data_sync;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_cnt_reg;
  logic            parity_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            ext_flag_reg, brk_flag_reg;
  logic            byte_valid_reg;
  logic [7:0]      byte_reg;
  ps2_key_t        key_reg;
  logic            frame_err_reg;
  logic            timeout, frame_ok, frame_bad;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .fe         (fe),
    .data_sync  (data_sync)
  );

  // An edge arriving in the expiry cycle wins over the timeout.
  assign timeout = (state_reg != IDLE) && !fe &&
                   (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = IDLE;
    end else if (fe) begin
      case (state_reg)
        IDLE:    if (!data_sync) state_next = DATA;
        DATA:    if (bit_cnt_reg == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (fe && state_reg == STOP) begin
      frame_ok  = data_sync && ((^shift_reg) ^ parity_reg);
      frame_bad = !frame_ok;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 3'd0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
    end else if (fe) begin
      to_cnt_reg <= '0;
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= 3'd0;
          shift_reg   <= 8'h00;
        end
        DATA: begin
          shift_reg[bit_cnt_reg] <= data_sync;
          bit_cnt_reg            <= bit_cnt_reg + 3'd1;
        end
        PARITY:  parity_reg <= data_sync;
        default: ;
      endcase
    end else if (state_reg != IDLE && !timeout) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end else begin
      to_cnt_reg <= '0;
    end
  end

  // Accepted byte is staged one cycle, then interpreted against the prefix flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid_reg <= 1'b0;
      byte_reg       <= 8'h00;
      frame_err_reg  <= 1'b0;
      ext_flag_reg   <= 1'b0;
      brk_flag_reg   <= 1'b0;
      key_reg        <= '0;
    end else begin
      byte_valid_reg <= frame_ok;
      if (frame_ok) byte_reg <= shift_reg;
      frame_err_reg <= frame_bad | timeout;
      if (frame_bad || timeout) begin
        ext_flag_reg <= 1'b0;
        brk_flag_reg <= 1'b0;
      end else if (byte_valid_reg) begin
        if (byte_reg == PS2_EXT_PREFIX) begin
          ext_flag_reg <= 1'b1;
        end else if (byte_reg == PS2_BREAK_PREFIX) begin
          brk_flag_reg <= 1'b1;
        end else begin
          key_reg.toggle   <= ~key_reg.toggle;
          key_reg.pressed  <= ~brk_flag_reg;
          key_reg.extended <= ext_flag_reg;
          key_reg.code     <= byte_reg;
          ext_flag_reg     <= 1'b0;
          brk_flag_reg     <= 1'b0;
        end
      end
    end
  end

  assign ps2_key   = key_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed frames then randomized traffic.
module tb_ps2_key_decoder;

  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HALF = 12;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 2 + 4;
`else
  localparam int LAT = SYNC + 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        sbq[$];
  bit          m_tog, m_ext, m_brk;
  int          checks = 0;
  int          errors = 0;
  int unsigned last_stop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one call per received byte or aborted frame.
  task automatic model_byte(input logic [7:0] b, input bit err);
    exp_t e;
    if (err) begin
      e.is_err = 1'b1;
      e.key    = '0;
      sbq.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_tog    = ~m_tog;
      e.is_err = 1'b0;
      e.key    = {m_tog, ~m_brk, m_ext, b};
      sbq.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input bit b, input bit is_stop);
    ps2_data_in = b;
    wait_cyc(HALF);
    ps2_clk_in = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk_in = 1'b1;
  endtask

  // err_kind: 0 good, 1 inverted parity, 2 stop bit low
  task automatic send_frame(input logic [7:0] b, input int err_kind);
    model_byte(b, err_kind != 0);
    $display("frame byte=%02h err_kind=%0d", b, err_kind);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ (err_kind == 1), 1'b0);
    send_bit(err_kind != 2, 1'b1);
    ps2_data_in = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_timeout(input int nbits);
    model_byte(8'h00, 1'b1);
    $display("timeout frame after %0d data bits", nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2_data_in = 1'b1;
    wait_cyc(TMO + 10);
  endtask

  // Monitor: every key change or error pulse must match the queue head.
  initial begin : monitor
    logic [10:0] prev_key;
    exp_t        e;
    prev_key = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_key = '0;
      end else begin
        if (frame_err === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_err: got pulse expected none at cycle %0d", cyc);
          end else begin
            e = sbq.pop_front();
            check("event_is_err", 32'(1'b1), 32'(e.is_err));
          end
        end
        if (ps2_key !== prev_key) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got 0x%0h expected no change from 0x%0h", ps2_key, prev_key);
          end else begin
            e = sbq.pop_front();
            check("event_is_key", 32'(1'b0), 32'(e.is_err));
            check("key_value", 32'(ps2_key), 32'(e.key));
            check("key_latency", cyc - last_stop_cyc, LAT);
          end
          prev_key = ps2_key;
        end
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(3);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    wait_cyc(5);

    send_frame(8'h15, 0);
    check("make_15", 32'(ps2_key), 32'h615);
    send_frame(8'hF0, 0);
    check("after_f0_unchanged", 32'(ps2_key), 32'h615);
    send_frame(8'h15, 0);
    check("break_15", 32'(ps2_key), 32'h015);
    send_frame(8'hE0, 0);
    send_frame(8'h4A, 0);
    check("ext_make_4a", 32'(ps2_key), 32'h74A);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h4A, 0);
    check("ext_break_4a", 32'(ps2_key), 32'h14A);
    send_frame(8'h15, 1);
    check("bad_parity_unchanged", 32'(ps2_key), 32'h14A);
    send_frame(8'h15, 0);
    check("after_bad_parity", 32'(ps2_key), 32'h615);
    send_timeout(4);
    send_frame(8'hF0, 0);
    send_frame(8'h15, 0);
    check("after_timeout", 32'(ps2_key), 32'h015);

    // Reset in the middle of a frame that follows a break prefix.
    send_frame(8'hF0, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset_n     = 1'b0;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    wait_cyc(3);
    sbq.delete();
    m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    $display("reset asserted mid-frame");
    reset_n = 1'b1;
    wait_cyc(2);
    check("midframe_reset_key", 32'(ps2_key), 32'h000);
    send_frame(8'h15, 0);
    check("post_reset_15", 32'(ps2_key), 32'h615);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        send_timeout($urandom_range(0, 7));
      end else if (r <= 2) begin
        send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 2));
      end else begin
        case ($urandom_range(0, 5))
          0:       b = 8'hE0;
          1:       b = 8'hF0;
          2:       b = 8'hE1;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_frame(b, 0);
      end
    end

    for (int w = 0; w < 500 && sbq.size() != 0; w++) wait_cyc(1);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
